// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: ld/st via valid/grant data port, ALU pass-through, one writeback record per op
module mem_access #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [4:0]        rd_i,
  input  logic              regwen_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic [AWIDTH-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [DWIDTH-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [DWIDTH-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_regwen_o,
  output logic              fault_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        memwrite_q;
  logic        regwen_q;

  logic              accept;
  logic              ld_st;
  logic              bad_funct3;
  logic              misaligned;
  logic              fault_c;
  logic [3:0]        be_c;
  logic [DWIDTH-1:0] wdata_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [DWIDTH-1:0] load_c;

  assign ex_ready_o = (state == S_IDLE) && !reset;
  assign accept     = ex_valid_i && ex_ready_o;

  // Decode of the op being offered: fault detection and store lane placement.
  always_comb begin
    ld_st      = memread_i || memwrite_i;
    bad_funct3 = memwrite_i ? (funct3_i[2] || (funct3_i[1:0] == 2'b11))
                            : ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11));
    misaligned = ((funct3_i[1:0] == 2'b01) && alu_res_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (alu_res_i[1:0] != 2'b00));
    fault_c    = ld_st && (bad_funct3 || misaligned);
    be_c       = 4'b1111;
    wdata_c    = rs2_i;
    if (memwrite_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be_c    = 4'b0001 << alu_res_i[1:0];
          wdata_c = {4{rs2_i[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << {alu_res_i[1], 1'b0};
          wdata_c = {2{rs2_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load data extraction from the returned word, using the captured lane and width.
  always_comb begin
    byte_c = dmem_rdata_i[7:0];
    case (lane_q)
      2'd1:    byte_c = dmem_rdata_i[15:8];
      2'd2:    byte_c = dmem_rdata_i[23:16];
      2'd3:    byte_c = dmem_rdata_i[31:24];
      default: byte_c = dmem_rdata_i[7:0];
    endcase
    half_c = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'b0, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'b0, half_c};
      default: load_c = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      funct3_q     <= '0;
      lane_q       <= '0;
      memwrite_q   <= 1'b0;
      regwen_q     <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_data_o    <= '0;
      wb_rd_o      <= '0;
      wb_regwen_o  <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            funct3_q   <= funct3_i;
            lane_q     <= alu_res_i[1:0];
            memwrite_q <= memwrite_i;
            regwen_q   <= regwen_i;
            wb_rd_o    <= rd_i;
            if (fault_c) begin
              state       <= S_OUT;
              wb_valid_o  <= 1'b1;
              wb_data_o   <= '0;
              wb_regwen_o <= 1'b0;
              fault_o     <= 1'b1;
            end else if (ld_st) begin
              state        <= S_REQ;
              dmem_req_o   <= 1'b1;
              dmem_addr_o  <= {alu_res_i[AWIDTH-1:2], 2'b00};
              dmem_we_o    <= memwrite_i;
              dmem_be_o    <= be_c;
              dmem_wdata_o <= memwrite_i ? wdata_c : '0;
            end else begin
              state       <= S_OUT;
              wb_valid_o  <= 1'b1;
              wb_data_o   <= alu_res_i;
              wb_regwen_o <= regwen_i;
              fault_o     <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (memwrite_q) begin
              state       <= S_OUT;
              wb_valid_o  <= 1'b1;
              wb_data_o   <= '0;
              wb_regwen_o <= 1'b0;
              fault_o     <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            state       <= S_OUT;
            wb_valid_o  <= 1'b1;
            wb_data_o   <= load_c;
            wb_regwen_o <= regwen_q;
            fault_o     <= 1'b0;
          end
        end
        S_OUT: begin
          if (wb_ready_i) begin
            state      <= S_IDLE;
            wb_valid_o <= 1'b0;
            fault_o    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access with random stimulus and a behavioural model
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_i, ex_ready_o;
  logic [31:0] alu_res_i, rs2_i;
  logic [2:0]  funct3_i;
  logic        memread_i, memwrite_i;
  logic [4:0]  rd_i;
  logic        regwen_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        dmem_rvalid_i;
  logic        wb_valid_o, wb_ready_i;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_regwen_o, fault_o;

  mem_access #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .alu_res_i(alu_res_i), .rs2_i(rs2_i), .funct3_i(funct3_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i), .rd_i(rd_i), .regwen_i(regwen_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_addr_o(dmem_addr_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
    .wb_rd_o(wb_rd_o), .wb_regwen_o(wb_regwen_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwen;
    logic        fault;
    logic        chk_data;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  wb_exp_t  wb_q[$];
  mem_exp_t mem_q[$];
  logic [31:0] mem [16];

  int tests = 0;
  int fails = 0;
  int gnt_prob = 100, rv_prob = 100, rdy_prob = 100, spur_prob = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: kind 0 = ALU op, 1 = load, 2 = store.
  function automatic void model(input int kind, input logic [31:0] res, input logic [31:0] rs2v,
                                input logic [2:0] f3, input logic [4:0] rd, input logic rw);
    wb_exp_t  w;
    mem_exp_t m;
    int size, off;
    logic illegal, flt;
    logic [31:0] word;
    longint v, full;
    size = 1 << (f3 % 4);
    off  = int'(res % 4);
    illegal = (kind == 1) ? (f3 == 3 || f3 == 6 || f3 == 7) : (kind == 2) ? (f3 > 2) : 1'b0;
    flt = (kind != 0) && (illegal || ((res % size) != 0));
    w.rd = rd;
    w.fault = flt;
    w.regwen = (kind == 0 || (kind == 1 && !flt)) ? rw : 1'b0;
    w.chk_data = (kind == 0 || (kind == 1 && !flt));
    w.data = res;
    if (!flt && kind != 0) begin
      m.addr = res & 32'hFFFF_FFFC;
      m.we = (kind == 2);
      m.be = 4'hF;
      m.wdata = 32'h0;
      if (kind == 2) begin
        m.be = 4'((1 << size) - 1) << off;
        if (size == 1)      m.wdata = (rs2v & 32'hFF) * 32'h0101_0101;
        else if (size == 2) m.wdata = (rs2v & 32'hFFFF) * 32'h0001_0001;
        else                m.wdata = rs2v;
      end else begin
        word = mem[res[5:2]];
        full = longint'(1) << (8 * size);
        v = {32'b0, word};
        v = (v >> (8 * off)) % full;
        if (f3 < 4 && size < 4 && v >= full / 2) v = v - full;
        w.data = v[31:0];
      end
      mem_q.push_back(m);
    end
    wb_q.push_back(w);
  endfunction

  task automatic issue(input int kind, input logic [31:0] res, input logic [31:0] rs2v,
                       input logic [2:0] f3, input logic [4:0] rd, input logic rw);
    int waitc;
    @(posedge clk); #1;
    ex_valid_i = 1'b1; alu_res_i = res; rs2_i = rs2v; funct3_i = f3;
    memread_i = (kind == 1); memwrite_i = (kind == 2); rd_i = rd; regwen_i = rw;
    waitc = 0;
    @(negedge clk);
    while (!ex_ready_o && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (!ex_ready_o) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      model(kind, res, rs2v, f3, rd, rw);
    end
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
  endtask

  task automatic directed(input string name, input int kind, input logic [31:0] res,
                          input logic [31:0] rs2v, input logic [2:0] f3, input int exp_lat,
                          input logic exp_fault, input logic chk, input logic [31:0] exp_data);
    int lat;
    issue(kind, res, rs2v, f3, 5'd5, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wb_valid_o && lat < 20);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_fault"}, 64'(fault_o), 64'(exp_fault));
    if (chk) check({name, "_data"}, 64'(wb_data_o), 64'(exp_data));
  endtask

  // Memory and writeback responder: grant, read return, spurious rvalid, wb back-pressure.
  initial begin
    logic       pending;
    logic [3:0] pend_idx;
    pending = 1'b0; pend_idx = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; wb_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && dmem_req_o && dmem_gnt_i && !dmem_we_o) begin
        pending = 1'b1;
        pend_idx = dmem_addr_o[5:2];
      end
      @(posedge clk); #1;
      dmem_gnt_i = ($urandom % 100) < gnt_prob;
      wb_ready_i = ($urandom % 100) < rdy_prob;
      if (pending && ($urandom % 100) < rv_prob) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = mem[pend_idx];
        pending = 1'b0;
      end else if (!pending && ($urandom % 100) < spur_prob) begin
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = $urandom;
      end else begin
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = $urandom;
      end
    end
  end

  // Monitor: pops expectations on each handshake and checks outputs hold while stalled.
  initial begin
    wb_exp_t     e;
    mem_exp_t    m;
    logic        wb_held, mem_held;
    logic [38:0] wb_saved;
    logic [31:0] addr_saved;
    logic [36:0] req_saved;
    wb_held = 1'b0; mem_held = 1'b0; wb_saved = '0; addr_saved = '0; req_saved = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wb_held = 1'b0;
        mem_held = 1'b0;
      end else begin
        if (wb_valid_o) begin
          if (wb_held) check("wb_hold", 64'({wb_data_o, wb_rd_o, wb_regwen_o, fault_o}), 64'(wb_saved));
          if (wb_ready_i) begin
            if (wb_q.size() == 0) begin
              check("wb_unexpected", 64'd1, 64'd0);
            end else begin
              e = wb_q.pop_front();
              if (e.chk_data) check("wb_data", 64'(wb_data_o), 64'(e.data));
              check("wb_rd", 64'(wb_rd_o), 64'(e.rd));
              check("wb_regwen", 64'(wb_regwen_o), 64'(e.regwen));
              check("wb_fault", 64'(fault_o), 64'(e.fault));
            end
            wb_held = 1'b0;
          end else begin
            wb_held = 1'b1;
            wb_saved = {wb_data_o, wb_rd_o, wb_regwen_o, fault_o};
          end
        end else begin
          if (wb_held) check("wb_dropped", 64'd0, 64'd1);
          wb_held = 1'b0;
        end
        if (dmem_req_o) begin
          if (mem_held) begin
            check("req_hold_addr", 64'(dmem_addr_o), 64'(addr_saved));
            check("req_hold_ctl", 64'({dmem_we_o, dmem_be_o, dmem_wdata_o}), 64'(req_saved));
          end
          if (dmem_gnt_i) begin
            if (mem_q.size() == 0) begin
              check("req_unexpected", 64'd1, 64'd0);
            end else begin
              m = mem_q.pop_front();
              check("req_addr", 64'(dmem_addr_o), 64'(m.addr));
              check("req_we", 64'(dmem_we_o), 64'(m.we));
              check("req_be", 64'(dmem_be_o), 64'(m.be));
              if (m.we) check("req_wdata", 64'(dmem_wdata_o), 64'(m.wdata));
            end
            mem_held = 1'b0;
          end else begin
            mem_held = 1'b1;
            addr_saved = dmem_addr_o;
            req_saved = {dmem_we_o, dmem_be_o, dmem_wdata_o};
          end
        end else begin
          if (mem_held) check("req_dropped", 64'd0, 64'd1);
          mem_held = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, waitc;
    logic [31:0] res;
    logic [2:0]  f3;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h8000_0000;
    reset = 1'b1;
    ex_valid_i = 1'b0; alu_res_i = '0; rs2_i = '0; funct3_i = '0;
    memread_i = 1'b0; memwrite_i = 1'b0; rd_i = '0; regwen_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(ex_ready_o), 64'd0);
    check("reset_outs", 64'({dmem_req_o, dmem_we_o, dmem_be_o, wb_valid_o, wb_rd_o, wb_regwen_o, fault_o}), 64'd0);
    check("reset_data", 64'({dmem_addr_o, wb_data_o}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(ex_ready_o), 64'd1);

    directed("alu",  0, 32'h0000_002A, 32'h0,         3'b000, 1, 1'b0, 1'b1, 32'h0000_002A);
    directed("sw",   2, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 2, 1'b0, 1'b0, 32'h0);
    directed("sh",   2, 32'h0000_0102, 32'h1234_ABCD, 3'b001, 2, 1'b0, 1'b0, 32'h0);
    directed("lb",   1, 32'h0000_0103, 32'h0,         3'b000, 3, 1'b0, 1'b1, 32'hFFFF_FF80);
    directed("lbu",  1, 32'h0000_0103, 32'h0,         3'b100, 3, 1'b0, 1'b1, 32'h0000_0080);
    directed("lhu",  1, 32'h0000_0102, 32'h0,         3'b101, 3, 1'b0, 1'b1, 32'h0000_8000);
    directed("lwmis",1, 32'h0000_0102, 32'h0,         3'b010, 1, 1'b1, 1'b0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      if (n % 25 == 0) begin
        gnt_prob = $urandom_range(25, 100);
        rv_prob = $urandom_range(25, 100);
        rdy_prob = $urandom_range(25, 100);
        spur_prob = $urandom_range(0, 50);
      end
      kind = $urandom_range(0, 2);
      res = (kind == 0) ? $urandom : 32'h100 + $urandom_range(0, 63);
      f3 = 3'($urandom_range(0, 7));
      issue(kind, res, $urandom, f3, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    waitc = 0;
    while ((wb_q.size() != 0 || mem_q.size() != 0) && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    check("drain", 64'(wb_q.size() + mem_q.size()), 64'd0);

    // Reset while waiting for read data; a late rvalid must not produce a record.
    gnt_prob = 100; rv_prob = 0; rdy_prob = 100; spur_prob = 0;
    repeat (2) @(posedge clk);
    issue(1, 32'h0000_0104, 32'h0, 3'b010, 5'd7, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(wb_q.pop_back());
    rv_prob = 100;
    @(negedge clk);
    check("rst_wait_req", 64'(dmem_req_o), 64'd0);
    check("rst_wait_wbv", 64'(wb_valid_o), 64'd0);
    check("rst_wait_ready", 64'(ex_ready_o), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("late_rvalid_no_wb", 64'(wb_valid_o), 64'd0);
    end
    check("final_queues", 64'(wb_q.size() + mem_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
